// File: rtl/cosim_reg_write_queue_pkg.sv
// Shared constants and record types for the cosim register-write queue.
// Register-type codes, default widths and packed key/record layouts.
package cosim_constants_pkg;

  localparam int NUM_PORTS_DEF  = 2;
  localparam int DEPTH_DEF      = 16;
  localparam int KEY_ID_W_DEF   = 60;
  localparam int KEY_TYPE_W_DEF = 4;
  localparam int VAL_W_DEF      = 128;
  localparam int XREG_W_DEF     = 64;

  typedef enum logic [KEY_TYPE_W_DEF-1:0] {
    REG_TYPE_X     = 4'd0,
    REG_TYPE_F     = 4'd1,
    REG_TYPE_V     = 4'd2,
    REG_TYPE_VHINT = 4'd3,
    REG_TYPE_CSR   = 4'd4
  } reg_type_e;

  typedef struct packed {
    logic [KEY_ID_W_DEF-1:0]   id;
    logic [KEY_TYPE_W_DEF-1:0] rtype;
  } reg_key_t;

  typedef struct packed {
    reg_key_t               key;
    logic [VAL_W_DEF-1:0]   val;
  } reg_wr_rec_t;

endpackage

// File: rtl/cosim_reg_write_queue_if.sv
// Commit-port push side and comparator pop side of the write queue.
// master = producer/consumer environment, slave = the queue.
interface cosim_reg_write_queue_if
  import cosim_constants_pkg::*;
#(
  parameter int NUM_PORTS  = NUM_PORTS_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int KEY_ID_W   = KEY_ID_W_DEF,
  parameter int KEY_TYPE_W = KEY_TYPE_W_DEF,
  parameter int VAL_W      = VAL_W_DEF
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [NUM_PORTS-1:0]                 in_valid_i;
  logic [NUM_PORTS-1:0][KEY_TYPE_W-1:0] in_type_i;
  logic [NUM_PORTS-1:0][KEY_ID_W-1:0]   in_id_i;
  logic [NUM_PORTS-1:0][VAL_W-1:0]      in_val_i;
  logic                                 in_ready_o;
  logic                                 out_valid_o;
  logic                                 out_ready_i;
  logic [KEY_ID_W+KEY_TYPE_W-1:0]       out_key_o;
  logic [VAL_W-1:0]                     out_val_o;
  logic [CW-1:0]                        count_o;

  modport master (
    output in_valid_i, in_type_i, in_id_i, in_val_i,
    output out_ready_i,
    input  in_ready_o, out_valid_o, out_key_o,
    input  out_val_o, count_o
  );

  modport slave (
    input  in_valid_i, in_type_i, in_id_i, in_val_i,
    input  out_ready_i,
    output in_ready_o, out_valid_o, out_key_o,
    output out_val_o, count_o
  );

endinterface

// File: rtl/cosim_lane_compactor.sv
// Prefix sum over per-lane valids: slot offset of each lane and
// the number of valid lanes, so gaps between valid lanes vanish.
module cosim_lane_compactor #(
  parameter int N  = 2,
  parameter int OW = $clog2(N + 1)
) (
  input  logic [N-1:0]         valid_i,
  output logic [N-1:0][OW-1:0] offset_o,
  output logic [OW-1:0]        count_o
);

  logic [OW-1:0] acc;

  // running count of valid lanes below each lane
  always_comb begin
    acc      = '0;
    offset_o = '0;
    for (int i = 0; i < N; i++) begin
      offset_o[i] = acc;
      acc         = acc + OW'(valid_i[i]);
    end
    count_o = acc;
  end

endmodule

// File: rtl/cosim_reg_write_queue.sv
// Multi-port commit-record FIFO: compacts valid lanes into a ring
// and drains one record per cycle to the cosim comparator.
module cosim_reg_write_queue
  import cosim_constants_pkg::*;
#(
  parameter int NUM_PORTS  = NUM_PORTS_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int KEY_ID_W   = KEY_ID_W_DEF,
  parameter int KEY_TYPE_W = KEY_TYPE_W_DEF,
  parameter int VAL_W      = VAL_W_DEF,
  parameter int XREG_W     = XREG_W_DEF
) (
  input logic                  clk_i,
  input logic                  rst_i,
  input logic                  flush_i,
  cosim_reg_write_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(NUM_PORTS + 1);
  localparam int KW = KEY_ID_W + KEY_TYPE_W;
  localparam logic [VAL_W-1:0] XMASK = VAL_W'({XREG_W{1'b1}});

  typedef struct packed {
    logic [KEY_ID_W-1:0]   id;
    logic [KEY_TYPE_W-1:0] rtype;
  } key_t;

  typedef struct packed {
    key_t             key;
    logic [VAL_W-1:0] val;
  } rec_t;

  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [NUM_PORTS-1:0][OW-1:0] lane_off;
  logic [OW-1:0]                lane_cnt;
  logic                         in_ready;
  logic                         out_valid;
  logic                         push;
  logic                         pop;
  logic [PW-1:0]                slot;
  rec_t                         rec;
  rec_t                         head;

  cosim_lane_compactor #(
    .N  (NUM_PORTS),
    .OW (OW)
  ) u_compact (
    .valid_i  (bus.in_valid_i),
    .offset_o (lane_off),
    .count_o  (lane_cnt)
  );

  // handshake qualifiers derived from registered state only
  always_comb begin
    in_ready  = (CW'(DEPTH) - count_q) >= CW'(NUM_PORTS);
    out_valid = count_q != '0;
    push      = in_ready && (|bus.in_valid_i);
    pop       = out_valid && bus.out_ready_i;
  end

  // next pointer/count state; flush overrides push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(lane_cnt);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + (push ? CW'(lane_cnt) : CW'(0))
              - CW'(pop);
    end
  end

  // write compacted, type-masked lanes into consecutive ring slots
  always_comb begin
    mem_d = mem_q;
    slot  = '0;
    rec   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      slot = wr_ptr_q + PW'(lane_off[i]);
      rec.key.id    = bus.in_id_i[i];
      rec.key.rtype = bus.in_type_i[i];
      rec.val       = bus.in_val_i[i];
      if (bus.in_type_i[i] == KEY_TYPE_W'(REG_TYPE_X)) begin
        rec.val = bus.in_val_i[i] & XMASK;
      end
      if (push && !flush_i && bus.in_valid_i[i]) begin
        mem_d[slot] = rec;
      end
    end
  end

  // pointer and occupancy registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // record storage, intentionally left unreset
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // head presentation, zeroed while empty
  always_comb begin
    head            = mem_q[rd_ptr_q];
    bus.in_ready_o  = in_ready;
    bus.out_valid_o = out_valid;
    bus.count_o     = count_q;
    bus.out_key_o   = out_valid ? KW'(head.key) : '0;
    bus.out_val_o   = out_valid ? head.val : '0;
  end

endmodule

// File: tb/tb_cosim_reg_write_queue.sv
// Directed bench for cosim_reg_write_queue with a queue scoreboard.
// Expected records are queued when accepted and compared at the head.
module tb_cosim_reg_write_queue;
  import cosim_constants_pkg::*;

  localparam int NP = 2;
  localparam int D  = 16;

  logic clk = 1'b0;
  logic rst_i;
  logic flush_i;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  reg_wr_rec_t sb[$];

  cosim_reg_write_queue_if #(
    .NUM_PORTS(NP), .DEPTH(D), .KEY_ID_W(60),
    .KEY_TYPE_W(4), .VAL_W(128)
  ) bus ();

  cosim_reg_write_queue #(
    .NUM_PORTS(NP), .DEPTH(D), .KEY_ID_W(60),
    .KEY_TYPE_W(4), .VAL_W(128), .XREG_W(64)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [191:0] obs,
                     logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic lane(int p, logic [3:0] t, logic [59:0] id,
                      logic [127:0] v);
    bus.in_valid_i[p] = 1'b1;
    bus.in_type_i[p]  = t;
    bus.in_id_i[p]    = id;
    bus.in_val_i[p]   = v;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // check outputs against the model, update the model, cross one edge
  task automatic tick();
    reg_wr_rec_t r;
    logic        pop;
    #3;
    chk("count", 192'(bus.count_o), 192'(exp_cnt));
    chk("in_ready", 192'(bus.in_ready_o), 192'(exp_cnt <= D - NP));
    chk("out_valid", 192'(bus.out_valid_o), 192'(exp_cnt != 0));
    if (sb.size() != 0)
      chk("head", {bus.out_key_o, bus.out_val_o}, sb[0]);
    else
      chk("idle_out", {bus.out_key_o, bus.out_val_o}, 192'd0);
    if (flush_i) begin
      sb.delete();
    end else begin
      pop = bus.out_ready_i && (sb.size() != 0);
      if (pop) void'(sb.pop_front());
      if (exp_cnt <= D - NP) begin
        for (int i = 0; i < NP; i++) begin
          if (bus.in_valid_i[i]) begin
            r.key.id    = bus.in_id_i[i];
            r.key.rtype = bus.in_type_i[i];
            r.val       = bus.in_val_i[i];
            if (bus.in_type_i[i] == 4'd0)
              r.val = {64'd0, bus.in_val_i[i][63:0]};
            sb.push_back(r);
          end
        end
      end
    end
    exp_cnt = sb.size();
    @(posedge clk);
    #1;
    bus.in_valid_i = '0;
    flush_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    bus.in_valid_i = '0;
    bus.in_type_i = '0;
    bus.in_id_i = '0;
    bus.in_val_i = '0;
    bus.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    tick();

    // X record: upper half masked, one-cycle latency
    bus.out_ready_i = 1'b1;
    lane(0, 4'd0, 60'd5, {128{1'b1}});
    tick();
    chk("x_key", 192'(bus.out_key_o), 192'({60'd5, 4'd0}));
    chk("x_val", 192'(bus.out_val_o), 192'({64'd0, {64{1'b1}}}));
    tick();

    // two F lanes in one cycle pop in port order
    lane(0, 4'd1, 60'd1, rnd128());
    lane(1, 4'd1, 60'd2, rnd128());
    tick();
    chk("pair_cnt", 192'(bus.count_o), 192'd2);
    tick();
    tick();
    tick();

    // port 1 only after flush lands in slot 0
    flush_i = 1'b1;
    tick();
    lane(1, 4'd2, 60'd7, rnd128());
    tick();
    chk("gap_cnt", 192'(bus.count_o), 192'd1);
    chk("gap_key", 192'(bus.out_key_o), 192'({60'd7, 4'd2}));
    // count=1 with pop and push together
    lane(1, 4'd3, 60'd8, rnd128());
    tick();
    chk("empty_bd_v", 192'(bus.out_valid_o), 192'd1);
    chk("empty_bd_k", 192'(bus.out_key_o), 192'({60'd8, 4'd3}));
    tick();

    // fill to 15 with a pair wrapping slot 15 -> 0
    bus.out_ready_i = 1'b0;
    lane(0, 4'd4, 60'd100, rnd128());
    tick();
    for (int k = 0; k < 7; k++) begin
      lane(0, 4'd1, 60'(200 + 2 * k), rnd128());
      lane(1, 4'd0, 60'(201 + 2 * k), rnd128());
      tick();
    end
    chk("full_cnt", 192'(bus.count_o), 192'd15);
    chk("full_rdy", 192'(bus.in_ready_o), 192'd0);
    lane(0, 4'd1, 60'd999, rnd128());
    lane(1, 4'd1, 60'd998, rnd128());
    tick();
    bus.out_ready_i = 1'b1;
    tick();
    chk("rdy_back", 192'(bus.in_ready_o), 192'd1);
    repeat (15) tick();

    // flush with count 6 and a concurrent push and pop
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      lane(0, 4'd2, 60'(300 + k), rnd128());
      lane(1, 4'd1, 60'(310 + k), rnd128());
      tick();
    end
    chk("pre_flush", 192'(bus.count_o), 192'd6);
    flush_i = 1'b1;
    bus.out_ready_i = 1'b1;
    lane(0, 4'd1, 60'd400, rnd128());
    lane(1, 4'd1, 60'd401, rnd128());
    tick();
    chk("flush_cnt", 192'(bus.count_o), 192'd0);
    chk("flush_vld", 192'(bus.out_valid_o), 192'd0);
    repeat (3) tick();

    // asynchronous reset with count 9
    bus.out_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      lane(0, 4'd4, 60'(500 + k), rnd128());
      lane(1, 4'd0, 60'(510 + k), rnd128());
      tick();
    end
    lane(0, 4'd1, 60'd520, rnd128());
    tick();
    chk("pre_rst", 192'(bus.count_o), 192'd9);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_cnt", 192'(bus.count_o), 192'd0);
    chk("rst_vld", 192'(bus.out_valid_o), 192'd0);
    chk("rst_rdy", 192'(bus.in_ready_o), 192'd1);
    chk("rst_key", 192'(bus.out_key_o), 192'd0);
    chk("rst_val", 192'(bus.out_val_o), 192'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    sb.delete();
    exp_cnt = 0;
    bus.out_ready_i = 1'b1;
    lane(0, 4'd4, 60'd600, 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321);
    tick();
    chk("post_key", 192'(bus.out_key_o), 192'({60'd600, 4'd4}));
    chk("post_val", 192'(bus.out_val_o),
        192'(128'h1234_5678_9abc_def0_0fed_cba9_8765_4321));
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cosim_reg_write_queue.md
# cosim_reg_write_queue

Parametrised multi-port buffer for register-write commit records in the co-simulation path. Each cycle it accepts up to NUM_PORTS records from the core's commit ports. A record is a register-type field, a register-id field and a value. The block compacts the valid records in port order into a circular FIFO and drains them one per cycle to the cosim comparator over a valid/ready handshake. It generalises the fixed register-write record widths to configurable key and value widths and commit-port count, and adds type-aware value masking and flush.

## Interface
- NUM_PORTS, 2: commit ports per cycle, 1..4.
- DEPTH, 16: FIFO entries; power of two, ≥ 2·NUM_PORTS.
- KEY_ID_W, 60: register-id field width.
- KEY_TYPE_W, 4: register-type field width.
- VAL_W, 128: record value width; equals the float register width.
- XREG_W, 64: integer register width, ≤ VAL_W.
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  discard all buffered records.
- in_valid_i  in  [NUM_PORTS]  per-port record valid.
- in_type_i  in  [NUM_PORTS][KEY_TYPE_W]  register type.
- in_id_i  in  [NUM_PORTS][KEY_ID_W]  register id.
- in_val_i  in  [NUM_PORTS][VAL_W]  written value.
- in_ready_o  out  1  all ports may push this cycle.
- out_valid_o  out  1  head record present.
- out_ready_i  in  1  comparator consumes head.
- out_key_o  out  KEY_ID_W+KEY_TYPE_W  packed key: {id, type}, with type in the LSBs.
- out_val_o  out  VAL_W  head value.
- count_o  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- in_ready_o = (DEPTH − count) ≥ NUM_PORTS.
  - It is a function of registered state only and never depends on out_ready_i.
- Push handshake:
  - A push occurs when in_ready_o is 1 and at least one in_valid_i bit is set.
  - All valid lanes are accepted atomically.
  - Valid lanes are written to consecutive slots starting at wr_ptr, lowest port index first. Gaps between valid lanes are squeezed out.
  - in_valid_i asserted while in_ready_o is 0 is not accepted. The producer holds the records.
- Type-aware masking on write:
  - If type == REG_TYPE_X, bits VAL_W−1:XREG_W of the stored value are forced to 0.
  - All other types are stored unmodified.
- Pop handshake:
  - A pop occurs when out_valid_o and out_ready_i are both 1.
  - out_valid_o = (count ≠ 0).
  - out_key_o and out_val_o show the entry at rd_ptr, and are driven to 0 while out_valid_o is 0.
- Counter and pointers:
  - count_next = count + popcount(accepted lanes) − pop.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Push and pop in the same cycle are both applied.
- Flush:
  - flush_i sets count, wr_ptr and rd_ptr to 0 at the next edge.
  - Pushes and the pop in a flush cycle are discarded. Flush wins over both.
- Reset:
  - count_o = 0, out_valid_o = 0, in_ready_o = 1, out_key_o = 0, out_val_o = 0, pointers = 0.
  - Storage contents are not reset.
  - Reset asserted mid-operation drops all records immediately and asynchronously.

## Timing
- Push-to-out latency is 1 cycle: a record accepted at edge N is visible on out_* after edge N, provided the FIFO was empty.
- No combinational path from in_* to out_*, or from out_ready_i to in_ready_o.
- Sustained drain rate: 1 record per cycle.
- Full boundary:
  - At count = DEPTH − NUM_PORTS + 1, in_ready_o drops even if fewer lanes are valid. This conservative stall is intentional.
  - A pop in that cycle raises in_ready_o one cycle later.
- Empty boundary:
  - At count = 1 with a simultaneous pop and push, out_valid_o stays 1 and shows the new record.
- Wrap: a multi-lane push spanning slot DEPTH−1 to slot 0 writes contiguously modulo DEPTH.

## Structure
- cosim_constants_pkg holds:
  - REG_TYPE_X=0, REG_TYPE_F=1, REG_TYPE_V=2, REG_TYPE_VHINT=3, REG_TYPE_CSR=4.
  - The default widths.
  - A typedef reg_key_t as a packed struct {id, type}.
  - A typedef reg_wr_rec_t holding {key, val}.
- One sub-module, cosim_lane_compactor: a combinational prefix-sum over in_valid_i that gives each lane's slot offset and the accepted-lane popcount.
- Storage is a plain register array, DEPTH × (KEY_ID_W + KEY_TYPE_W + VAL_W).

## Test plan
- After reset, with out_ready_i=1:
  - Port 0 pushes X record id=5, val=128'hFFFF…FFFF.
  - Next cycle out_key_o={60'd5,4'd0}, out_val_o upper 64 bits 0, lower 64'hFFFF_FFFF_FFFF_FFFF.
- Ports 0 and 1 push F records id=1 and id=2 in one cycle:
  - Pop order is id=1 then id=2.
  - count_o goes 2, 1, 0.
- Only port 1 valid, id=7:
  - The record lands in slot 0 with no gap.
  - count_o = 1.
- With out_ready_i=0, fill to 15 with DEPTH=16 and NUM_PORTS=2:
  - in_ready_o = 0.
  - One pop restores in_ready_o = 1 the following cycle.
  - The wrapped pair pops in order.
- With count=6, assert flush_i together with a 2-lane push and out_ready_i=1:
  - Next cycle count_o = 0 and out_valid_o = 0.
  - No record is ever emitted.
- Assert rst_i mid-burst with count=9:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release the first push is popped with correct data.
